decode_queue: RTL and testbench

//  Parametrised successor to the single-shot decoder: buffers fetched RV32I instructions in a DEPTH-entry FIFO and decodes the head.

---
 rtl/decode_queue.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I fetch buffer: a DEPTH-entry FIFO feeding a registered decode stage.
// The decode stage presents fields to issue through a valid/ready handshake.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               op_type,
  output logic [2:0]               op_sub,
  output logic                     op_flag,
  output logic [31:0]              imm,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     uses_rs1,
  output logic                     uses_rs2,
  output logic                     writes_rd,
  output logic                     illegal,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]  op_type;
    logic [2:0]  op_sub;
    logic        op_flag;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } dec_t;

  logic [31:0]     fifo_instr_q [DEPTH];
  logic [PC_W-1:0] fifo_pc_q    [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  dec_t            dec_q, dec_d;

  logic            push;
  logic            pop;
  logic            bypass;
  logic            fifo_wr;
  logic            load;
  logic            out_free;
  logic            fifo_has;
  logic [31:0]     src_instr;
  logic [PC_W-1:0] src_pc;
  dec_t            dec_src;

  // in_ready looks only at the registered count so issue backpressure never
  // reaches fetch combinationally; a full FIFO blocks even if it pops this cycle.
  assign in_ready = (count_q < CW'(DEPTH));
  assign out_free = !out_valid_q || out_ready;
  assign fifo_has = (count_q != '0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_free && fifo_has && !flush;
  assign bypass   = out_free && !fifo_has && push;
  assign fifo_wr  = push && !bypass;
  assign load     = pop || bypass;

  always_comb begin
    src_instr = in_instr;
    src_pc    = in_pc;
    if (fifo_has) begin
      src_instr = fifo_instr_q[rd_ptr_q];
      src_pc    = fifo_pc_q[rd_ptr_q];
    end
  end

  always_comb begin
    logic has_f3;
    logic has_rd;
    dec_src         = '0;
    has_f3          = 1'b0;
    has_rd          = 1'b0;
    dec_src.op_type = src_instr[6:0];
    case (src_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec_src.imm = {src_instr[31:12], 12'b0};
        has_rd      = 1'b1;
      end
      OPC_JAL: begin
        dec_src.imm = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                       src_instr[20], src_instr[30:21], 1'b0};
        has_rd      = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        dec_src.imm      = {{20{src_instr[31]}}, src_instr[31:20]};
        dec_src.uses_rs1 = 1'b1;
        has_rd           = 1'b1;
        has_f3           = 1'b1;
      end
      OPC_BRANCH: begin
        dec_src.imm      = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                            src_instr[30:25], src_instr[11:8], 1'b0};
        dec_src.uses_rs1 = 1'b1;
        dec_src.uses_rs2 = 1'b1;
        has_f3           = 1'b1;
      end
      OPC_STORE: begin
        dec_src.imm      = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
        dec_src.uses_rs1 = 1'b1;
        dec_src.uses_rs2 = 1'b1;
        has_f3           = 1'b1;
      end
      OPC_OPIMM: begin
        // Shift amounts are unsigned and funct7 bit 30 selects arithmetic shift.
        if (src_instr[14:12] == 3'b001 || src_instr[14:12] == 3'b101) begin
          dec_src.imm     = {27'b0, src_instr[24:20]};
          dec_src.op_flag = src_instr[30];
        end else begin
          dec_src.imm = {{20{src_instr[31]}}, src_instr[31:20]};
        end
        dec_src.uses_rs1 = 1'b1;
        has_rd           = 1'b1;
        has_f3           = 1'b1;
      end
      OPC_OP: begin
        dec_src.op_flag  = src_instr[30];
        dec_src.uses_rs1 = 1'b1;
        dec_src.uses_rs2 = 1'b1;
        has_rd           = 1'b1;
        has_f3           = 1'b1;
      end
      OPC_MISC: begin
        has_f3 = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_src.imm = {{20{src_instr[31]}}, src_instr[31:20]};
        has_f3      = 1'b1;
      end
      default: begin
        dec_src.illegal = 1'b1;
      end
    endcase
    dec_src.op_sub    = has_f3 ? src_instr[14:12] : 3'b000;
    dec_src.rs1       = dec_src.uses_rs1 ? src_instr[19:15] : 5'd0;
    dec_src.rs2       = dec_src.uses_rs2 ? src_instr[24:20] : 5'd0;
    dec_src.rd        = has_rd ? src_instr[11:7] : 5'd0;
    dec_src.writes_rd = has_rd && (src_instr[11:7] != 5'd0);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    dec_d       = dec_q;
    if (flush) begin
      // Decoded fields deliberately keep their last values across a squash.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(fifo_wr) - CW'(pop);
      if (out_free) begin
        out_valid_d = load;
      end
      if (load) begin
        out_instr_d = src_instr;
        out_pc_d    = src_pc;
        dec_d       = dec_src;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      fifo_instr_q[wr_ptr_q] <= in_instr;
      fifo_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      dec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign count     = count_q;
  assign op_type   = dec_q.op_type;
  assign op_sub    = dec_q.op_sub;
  assign op_flag   = dec_q.op_flag;
  assign imm       = dec_q.imm;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign uses_rs1  = dec_q.uses_rs1;
  assign uses_rs2  = dec_q.uses_rs2;
  assign writes_rd = dec_q.writes_rd;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: accepted pushes are decoded by a reference
// model and queued, then compared field by field when issue takes the output.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [PC_W-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [6:0]             op_type;
  logic [2:0]             op_sub;
  logic                   op_flag;
  logic [31:0]            imm;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic [4:0]             rd;
  logic                   uses_rs1;
  logic                   uses_rs2;
  logic                   writes_rd;
  logic                   illegal;
  logic [PC_W-1:0]        out_pc;
  logic [31:0]            out_instr;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [6:0]  opType;
    logic [2:0]  opSub;
    logic        opFlag;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        usesRs1;
    logic        usesRs2;
    logic        writesRd;
    logic        illegal;
  } decT;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    decT         dec;
  } sbEntryT;

  sbEntryT     sbq[$];
  int          errors   = 0;
  int          checks   = 0;
  int          popCount = 0;
  logic [31:0] pcNext   = 32'h1000;
  logic        prevStall = 1'b0;
  logic [31:0] prevInstr, prevImm, prevPc;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_type(op_type), .op_sub(op_sub), .op_flag(op_flag), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
    .illegal(illegal), .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference decoder written straight from the RV32I field layouts.
  function automatic decT refDecode(input logic [31:0] w);
    decT        d;
    int         v;
    logic [6:0] opc;
    logic       hasRd;
    d = '0;
    opc = w[6:0];
    d.opType = opc;
    hasRd = 1'b0;
    if (opc == 7'h37 || opc == 7'h17) begin
      d.imm = w & 32'hFFFFF000;
      hasRd = 1'b1;
    end else if (opc == 7'h6F) begin
      v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      d.imm = v;
      hasRd = 1'b1;
    end else if (opc == 7'h67 || opc == 7'h03) begin
      v = $signed(w[31:20]);
      d.imm = v; d.opSub = w[14:12]; d.usesRs1 = 1'b1; hasRd = 1'b1;
    end else if (opc == 7'h63) begin
      v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      d.imm = v; d.opSub = w[14:12]; d.usesRs1 = 1'b1; d.usesRs2 = 1'b1;
    end else if (opc == 7'h23) begin
      v = $signed({w[31:25], w[11:7]});
      d.imm = v; d.opSub = w[14:12]; d.usesRs1 = 1'b1; d.usesRs2 = 1'b1;
    end else if (opc == 7'h13) begin
      if (w[13:12] == 2'b01) begin
        d.imm = 32'(w[24:20]);
        d.opFlag = w[30];
      end else begin
        v = $signed(w[31:20]);
        d.imm = v;
      end
      d.opSub = w[14:12]; d.usesRs1 = 1'b1; hasRd = 1'b1;
    end else if (opc == 7'h33) begin
      d.opSub = w[14:12]; d.opFlag = w[30];
      d.usesRs1 = 1'b1; d.usesRs2 = 1'b1; hasRd = 1'b1;
    end else if (opc == 7'h0F) begin
      d.opSub = w[14:12];
    end else if (opc == 7'h73) begin
      v = $signed(w[31:20]);
      d.imm = v; d.opSub = w[14:12];
    end else begin
      d.illegal = 1'b1;
    end
    if (d.usesRs1) d.rs1 = w[19:15];
    if (d.usesRs2) d.rs2 = w[24:20];
    if (hasRd) d.rd = w[11:7];
    d.writesRd = hasRd && (w[11:7] != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 12))
      0:  opc = 7'h37;
      1:  opc = 7'h17;
      2:  opc = 7'h6F;
      3:  opc = 7'h67;
      4:  opc = 7'h63;
      5:  opc = 7'h03;
      6:  opc = 7'h23;
      7:  opc = 7'h13;
      8:  opc = 7'h33;
      9:  opc = 7'h0F;
      10: opc = 7'h73;
      default: opc = r[6:0];
    endcase
    return {r[31:7], opc};
  endfunction

  // Monitor: handshakes are judged at the falling edge, mid-cycle.
  always @(negedge clock) begin
    if (reset || flush) begin
      sbq.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall && out_valid) begin
        checkOutput("stable_instr", out_instr, prevInstr);
        checkOutput("stable_pc", out_pc, prevPc);
        checkOutput("stable_imm", imm, prevImm);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_has_entry", 32'(sbq.size()), 32'd1);
        end else begin
          sbEntryT e;
          e = sbq.pop_front();
          popCount++;
          checkOutput("out_instr", out_instr, e.instr);
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("op_type", 32'(op_type), 32'(e.dec.opType));
          checkOutput("op_sub", 32'(op_sub), 32'(e.dec.opSub));
          checkOutput("op_flag", 32'(op_flag), 32'(e.dec.opFlag));
          checkOutput("imm", imm, e.dec.imm);
          checkOutput("rs1", 32'(rs1), 32'(e.dec.rs1));
          checkOutput("rs2", 32'(rs2), 32'(e.dec.rs2));
          checkOutput("rd", 32'(rd), 32'(e.dec.rd));
          checkOutput("uses_rs1", 32'(uses_rs1), 32'(e.dec.usesRs1));
          checkOutput("uses_rs2", 32'(uses_rs2), 32'(e.dec.usesRs2));
          checkOutput("writes_rd", 32'(writes_rd), 32'(e.dec.writesRd));
          checkOutput("illegal", 32'(illegal), 32'(e.dec.illegal));
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{instr: in_instr, pc: in_pc, dec: refDecode(in_instr)});
      end
      prevStall = out_valid && !out_ready;
      prevInstr = out_instr;
      prevPc    = out_pc;
      prevImm   = imm;
    end
  end

  task automatic applyStimulus(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pcNext;
    pcNext   = pcNext + 32'd4;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drainQueue(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(tag, 32'(sbq.size()) + 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] bpList [6];
    int          popBase;
    bpList[0] = 32'h00500093;
    bpList[1] = 32'hFE208CE3;
    bpList[2] = 32'h40225193;
    bpList[3] = 32'h123452B7;
    bpList[4] = 32'h00112623;
    bpList[5] = 32'h008000EF;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_imm", imm, 32'd0);
    checkOutput("rst_op_type", 32'(op_type), 32'd0);

    out_ready = 1'b1;
    applyStimulus(32'h00500093);
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_op_type", 32'(op_type), 32'h13);
    checkOutput("addi_rd", 32'(rd), 32'd1);
    checkOutput("addi_imm", imm, 32'd5);
    checkOutput("addi_uses_rs1", 32'(uses_rs1), 32'd1);
    checkOutput("addi_uses_rs2", 32'(uses_rs2), 32'd0);
    checkOutput("addi_writes_rd", 32'(writes_rd), 32'd1);
    applyStimulus(32'hFE208CE3);
    checkOutput("beq_rs1", 32'(rs1), 32'd1);
    checkOutput("beq_rs2", 32'(rs2), 32'd2);
    checkOutput("beq_imm", imm, 32'hFFFFFFF8);
    checkOutput("beq_writes_rd", 32'(writes_rd), 32'd0);
    applyStimulus(32'h40225193);
    checkOutput("srai_op_sub", 32'(op_sub), 32'd5);
    checkOutput("srai_op_flag", 32'(op_flag), 32'd1);
    checkOutput("srai_imm", imm, 32'd2);
    applyStimulus(32'h123452B7);
    checkOutput("lui_imm", imm, 32'h12345000);
    checkOutput("lui_rd", 32'(rd), 32'd5);
    applyStimulus(32'hFFFFFFFF);
    checkOutput("bad_illegal", 32'(illegal), 32'd1);
    checkOutput("bad_writes_rd", 32'(writes_rd), 32'd0);
    checkOutput("bad_uses_rs1", 32'(uses_rs1), 32'd0);
    checkOutput("bad_uses_rs2", 32'(uses_rs2), 32'd0);
    drainQueue("directed_drain");

    // Six back-to-back offers against a stalled consumer: capacity is DEPTH+1.
    out_ready = 1'b0;
    popBase = popCount;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_instr = bpList[i];
      in_pc    = pcNext;
      pcNext   = pcNext + 32'd4;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("full_count", 32'(count), 32'(DEPTH));
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_out_instr", out_instr, bpList[0]);
    checkOutput("full_sb_size", 32'(sbq.size()), 32'd5);
    repeat (3) @(posedge clock);
    #1;
    drainQueue("bp_drain");
    checkOutput("bp_pops", 32'(popCount - popBase), 32'd5);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_count", 32'(count), 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(bpList[i]);
    checkOutput("pre_flush_count", 32'(count), 32'd3);
    checkOutput("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = pcNext;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_keeps_instr", out_instr, bpList[0]);
    @(posedge clock);
    #1;
    checkOutput("flush_push_dropped", 32'(out_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = randInstr();
      in_pc     = pcNext;
      pcNext    = pcNext + 32'd4;
      @(posedge clock);
      #1;
    end
    drainQueue("random_drain");

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(bpList[i + 1]);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_rst_imm", imm, 32'd0);
    checkOutput("async_rst_instr", out_instr, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'h00500093);
    checkOutput("post_rst_imm", imm, 32'd5);
    drainQueue("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
